tilemap_writer: RTL and testbench
=================================

TILEMAP_WRITER -- requirements
Module: tilemap_writer

Interface
REQ-001 SHALL have parameter TILEMAP_RAM_WIDTH, default 10, width of the cell-index RAM address {y[4:0],x[4:0]}.
REQ-002 SHALL have parameter TILEMAP_CELLS_X, default 5'd22, cells per row.
REQ-003 SHALL have parameter TILEMAP_CELLS_Y, default 5'd17, cells per column.
REQ-004 SHALL have port clk  input  1  single clock, all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port addr  input  2  CPU register select.
REQ-007 SHALL have port data_in  input  8  CPU write data.
REQ-008 SHALL have port write  input  1  CPU write strobe, one cycle per access.
REQ-009 SHALL have port data_out  output  8  combinational CPU readback of the register at addr.
REQ-010 SHALL have port tilemap_busy  input  1  high while the tilemap engine owns the index RAM write port (scroll or clear in progress).
REQ-011 SHALL have port ram_addr  output  TILEMAP_RAM_WIDTH  index RAM write address.
REQ-012 SHALL have port ram_data  output  8  index RAM write data (tile number).
REQ-013 SHALL have port ram_wr  output  1  index RAM write enable.

Function
REQ-014 SHALL decode the registers as follows: 0 = cursor X, 1 = cursor Y, 2 = data push, 3 = status/control.
REQ-015 A write to reg 0 or reg 1 SHALL load the cursor, clamping values >= CELLS to CELLS-1.
REQ-016 A write to reg 2 SHALL push {cursor Y, cursor X, data_in} into a 4-entry FIFO and latch data_in as last_data.
REQ-017 Reads SHALL return: reg0 cursor X zero-extended; reg1 cursor Y zero-extended; reg2 last_data; reg3 status = {autoinc_compiled, 3'b0, busy, overflow, empty, full}.
REQ-018 A push while full SHALL be dropped and SHALL set sticky overflow, evaluated before any same-cycle pop; cursor and last_data SHALL still update.
REQ-019 A write to reg 3 with data_in[2]=1 SHALL clear overflow; other bits of that write SHALL be ignored.
REQ-020 The drain FSM SHALL have states IDLE, SETUP, WRITE and RELEASE.
REQ-021 IDLE -> SETUP SHALL occur when the FIFO is not empty and tilemap_busy=0; SETUP SHALL drive ram_addr/ram_data from the FIFO head with ram_wr=0.
REQ-022 SETUP -> WRITE SHALL occur if tilemap_busy=0 (ram_wr=1 for exactly one cycle); otherwise SETUP -> IDLE with no write and no pop.
REQ-023 WRITE -> RELEASE SHALL be unconditional: ram_wr=0, head popped; RELEASE -> IDLE SHALL be unconditional.
REQ-024 Latency from push into an empty FIFO with tilemap_busy=0 to ram_wr high SHALL be 3 cycles; sustained throughput SHALL be one write per 4 cycles.
REQ-025 busy SHALL be 1 whenever the FSM is not in IDLE or the FIFO is not empty.
REQ-026 ram_addr and ram_data SHALL hold their last values while the FSM is in IDLE.
REQ-027 Simultaneous push and pop SHALL keep the count unchanged and preserve ordering.

Reset
REQ-028 Reset SHALL asynchronously force ram_wr=0, ram_addr=0, ram_data=0, cursor=(0,0), last_data=0, FIFO empty, overflow=0, FSM=IDLE.
REQ-029 Reset during WRITE SHALL drop ram_wr immediately and discard all queued entries.

Configuration
REQ-030 Macro TILEMAP_WRITER_AUTOINC_EN SHALL control cursor auto-advance and the autoinc_compiled status bit.
REQ-031 When TILEMAP_WRITER_AUTOINC_EN is defined, each reg-2 write, including a dropped one, SHALL advance X after the push; X=CELLS_X-1 SHALL wrap to 0 with Y+1, and (CELLS_X-1,CELLS_Y-1) SHALL wrap to (0,0); status bit7 SHALL read 1.
REQ-032 When TILEMAP_WRITER_AUTOINC_EN is not defined, the cursor SHALL change only on reg 0/1 writes, and status bit7 SHALL read 0.

Verification
REQ-033 Set X=3, Y=2, push 0x41, tilemap_busy=0 -> ram_wr high exactly 1 cycle, 3 cycles after the push, with ram_addr=0x043 and ram_data=0x41.
REQ-034 tilemap_busy=1 and push 5 values -> status full=1, overflow=1, no ram_wr; after busy drops, exactly 4 writes in push order; status empty=1; writing 0x04 to reg 3 clears overflow.
REQ-035 AUTOINC_EN defined, cursor (21,16), push twice -> writes to addr {16,21}=0x215 then 0x000; cursor reads (1,0).
REQ-036 tilemap_busy rises in the SETUP cycle -> no ram_wr that pass; the entry is written after busy falls.
REQ-037 Reset asserted during WRITE -> ram_wr low in the same cycle; status reads 0x02 (or 0x82 with AUTOINC_EN); no further writes occur.

Source files
------------

// File: rtl/tilemap_writer.sv
// tilemap_writer: CPU register front-end queuing tile writes into the tilemap index RAM.
// Define TILEMAP_WRITER_AUTOINC_EN to advance the cursor after every data push.
module tilemap_writer #(
  parameter int         TILEMAP_RAM_WIDTH = 10,
  parameter logic [4:0] TILEMAP_CELLS_X   = 5'd22,
  parameter logic [4:0] TILEMAP_CELLS_Y   = 5'd17
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [1:0]                   addr,
  input  logic [7:0]                   data_in,
  input  logic                         write,
  output logic [7:0]                   data_out,
  input  logic                         tilemap_busy,
  output logic [TILEMAP_RAM_WIDTH-1:0] ram_addr,
  output logic [7:0]                   ram_data,
  output logic                         ram_wr
);
  typedef enum logic [1:0] {IDLE, SETUP, WRITE, RELEASE} state_t;
`ifdef TILEMAP_WRITER_AUTOINC_EN
  localparam logic AUTOINC = 1'b1;
`else
  localparam logic AUTOINC = 1'b0;
`endif
  state_t r_state, w_next;
  logic [4:0] r_cx, r_cy;
  logic [7:0] r_last;
  logic r_ovf;
  logic [17:0] r_fifo [4];
  logic [1:0] r_wp, r_rp;
  logic [2:0] r_cnt;
  logic [TILEMAP_RAM_WIDTH-1:0] r_ram_addr;
  logic [7:0] r_ram_data;
  logic w_full, w_empty, w_push, w_push_ok, w_pop, w_busy;
  logic [17:0] w_head;
  function automatic logic [4:0] clamp(input logic [7:0] v, input logic [4:0] n);
    return (v >= {3'b0, n}) ? n - 5'd1 : v[4:0];
  endfunction
  assign w_full    = r_cnt == 3'd4;
  assign w_empty   = r_cnt == 3'd0;
  assign w_push    = write && addr == 2'd2;
  assign w_push_ok = w_push && !w_full;
  assign w_pop     = r_state == WRITE;
  assign w_busy    = r_state != IDLE || !w_empty;
  assign w_head    = r_fifo[r_rp];
  assign ram_addr  = r_ram_addr;
  assign ram_data  = r_ram_data;
  assign ram_wr    = r_state == WRITE;
  always_comb begin
    data_out = addr == 2'd0 ? {3'b0, r_cx} :
               addr == 2'd1 ? {3'b0, r_cy} :
               addr == 2'd2 ? r_last :
               {AUTOINC, 3'b0, w_busy, r_ovf, w_empty, w_full};
  end
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE  ? ((!w_empty && !tilemap_busy) ? SETUP : IDLE) :
             r_state == SETUP ? (tilemap_busy ? IDLE : WRITE) :
             r_state == WRITE ? RELEASE : IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ram_addr <= '0;
      r_ram_data <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next == SETUP) begin
        r_ram_addr <= TILEMAP_RAM_WIDTH'(w_head[17:8]);
        r_ram_data <= w_head[7:0];
      end
    end
  end
  // the entry captures the cursor as it stands before any auto-advance
  always_ff @(posedge clk) begin
    if (w_push_ok) r_fifo[r_wp] <= {r_cy, r_cx, data_in};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push_ok) r_wp <= r_wp + 2'd1;
      if (w_pop) r_rp <= r_rp + 2'd1;
      r_cnt <= r_cnt + {2'b0, w_push_ok} - {2'b0, w_pop};
      if (w_push && w_full) r_ovf <= 1'b1;
      else if (write && addr == 2'd3 && data_in[2]) r_ovf <= 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cx   <= '0;
      r_cy   <= '0;
      r_last <= '0;
    end else begin
      if (w_push) r_last <= data_in;
      if (write && addr == 2'd0) r_cx <= clamp(data_in, TILEMAP_CELLS_X);
      else if (write && addr == 2'd1) r_cy <= clamp(data_in, TILEMAP_CELLS_Y);
`ifdef TILEMAP_WRITER_AUTOINC_EN
      else if (w_push) begin
        r_cx <= (r_cx == TILEMAP_CELLS_X - 5'd1) ? 5'd0 : r_cx + 5'd1;
        if (r_cx == TILEMAP_CELLS_X - 5'd1)
          r_cy <= (r_cy == TILEMAP_CELLS_Y - 5'd1) ? 5'd0 : r_cy + 5'd1;
      end
`endif
    end
  end
endmodule

// File: tb/tb_tilemap_writer.sv
// tb_tilemap_writer: directed stimulus with a write-port scoreboard for tilemap_writer.
module tb_tilemap_writer;
  logic clk, reset, write, tilemap_busy, ram_wr;
  logic [1:0] addr;
  logic [7:0] data_in, data_out, ram_data;
  logic [9:0] ram_addr;
  logic [17:0] exp_q[$];
  int n_cmp = 0, n_bad = 0, nwr = 0;
`ifdef TILEMAP_WRITER_AUTOINC_EN
  localparam logic [7:0] AI = 8'h80;
  localparam int AINC = 1;
`else
  localparam logic [7:0] AI = 8'h00;
  localparam int AINC = 0;
`endif

  tilemap_writer dut (
    .clk(clk), .reset(reset), .addr(addr), .data_in(data_in), .write(write),
    .data_out(data_out), .tilemap_busy(tilemap_busy), .ram_addr(ram_addr),
    .ram_data(ram_data), .ram_wr(ram_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; data_in = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [1:0] a, input logic [7:0] exp);
    addr = a;
    #1 chk(nm, data_out, exp);
  endtask

  task automatic push(input logic [4:0] x, input logic [4:0] y, input logic [7:0] d, input bit expect_wr);
    wr(2'd0, {3'b0, x});
    wr(2'd1, {3'b0, y});
    if (expect_wr) exp_q.push_back({y, x, d});
    wr(2'd2, d);
  endtask

  always @(negedge clk) begin
    if (!reset && ram_wr) begin
      nwr++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h required no write", ram_addr, ram_data);
      end else begin
        chk("ram_write", {14'b0, ram_addr, ram_data}, {14'b0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    int n0, k;
    reset = 1'b1; write = 1'b0; addr = 2'd0; data_in = 8'h00; tilemap_busy = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("rst_ram_wr", ram_wr, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_data", ram_data, 0);
    rd("rst_status", 2'd3, AI | 8'h02);
    rd("rst_cx", 2'd0, 8'd0);
    rd("rst_last", 2'd2, 8'd0);
    reset = 1'b0;

    // single push: ram_wr exactly in the third cycle after the push
    wr(2'd0, 8'd3);
    wr(2'd1, 8'd2);
    exp_q.push_back({10'h043, 8'h41});
    wr(2'd2, 8'h41);
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) @(negedge clk);
      #1 chk($sformatf("latency_c%0d", i), ram_wr, (i == 3) ? 1 : 0);
    end
    rd("last_data", 2'd2, 8'h41);
    rd("cx_after_push", 2'd0, 8'(3 + AINC));
    rd("cy_after_push", 2'd1, 8'd2);

    wr(2'd0, 8'd30);  rd("clamp_x30", 2'd0, 8'd21);
    wr(2'd0, 8'd22);  rd("clamp_x22", 2'd0, 8'd21);
    wr(2'd0, 8'd21);  rd("keep_x21", 2'd0, 8'd21);
    wr(2'd1, 8'd200); rd("clamp_y200", 2'd1, 8'd16);
    wr(2'd1, 8'd17);  rd("clamp_y17", 2'd1, 8'd16);
    wr(2'd1, 8'd16);  rd("keep_y16", 2'd1, 8'd16);

    // fill while engine busy, overflow on the fifth push
    tilemap_busy = 1'b1;
    n0 = nwr;
    for (int i = 0; i < 5; i++) push(5'(i), 5'd1, 8'(8'h10 + i), i < 4);
    rd("full_status", 2'd3, AI | 8'h0D);
    rd("dropped_last", 2'd2, 8'h14);
    chk("no_write_busy", nwr - n0, 0);
    tilemap_busy = 1'b0;
    repeat (20) @(negedge clk);
    chk("drain_count", nwr - n0, 4);
    chk("drain_queue", exp_q.size(), 0);
    rd("drained_status", 2'd3, AI | 8'h06);
    wr(2'd3, 8'hFB);
    rd("ovf_kept", 2'd3, AI | 8'h06);
    wr(2'd3, 8'h04);
    rd("ovf_cleared", 2'd3, AI | 8'h02);

    // cursor wrap at the last cell
    wr(2'd0, 8'd21);
    wr(2'd1, 8'd16);
`ifdef TILEMAP_WRITER_AUTOINC_EN
    exp_q.push_back({10'h215, 8'hA1});
    exp_q.push_back({10'h000, 8'hA2});
`else
    exp_q.push_back({10'h215, 8'hA1});
    exp_q.push_back({10'h215, 8'hA2});
`endif
    wr(2'd2, 8'hA1);
    wr(2'd2, 8'hA2);
    repeat (15) @(negedge clk);
    rd("wrap_cx", 2'd0, AINC ? 8'd1 : 8'd21);
    rd("wrap_cy", 2'd1, AINC ? 8'd0 : 8'd16);
    chk("wrap_queue", exp_q.size(), 0);

    // busy rises during SETUP: that pass aborts, entry written later
    push(5'd5, 5'd7, 8'h77, 1'b1);
    @(negedge clk);
    tilemap_busy = 1'b1;
    n0 = nwr;
    repeat (8) @(negedge clk);
    chk("setup_abort", nwr - n0, 0);
    rd("abort_status", 2'd3, AI | 8'h08);
    tilemap_busy = 1'b0;
    repeat (8) @(negedge clk);
    chk("setup_retry", nwr - n0, 1);

    // reset while in WRITE discards the remaining entry
    tilemap_busy = 1'b1;
    push(5'd1, 5'd1, 8'h31, 1'b1);
    push(5'd2, 5'd1, 8'h32, 1'b0);
    @(negedge clk);
    tilemap_busy = 1'b0;
    k = 0;
    while (!ram_wr && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("reach_write", ram_wr, 1);
    #2 reset = 1'b1;
    #1 chk("rst_drop_wr", ram_wr, 0);
    chk("rst_drop_addr", ram_addr, 0);
    chk("rst_drop_data", ram_data, 0);
    @(negedge clk);
    reset = 1'b0;
    n0 = nwr;
    repeat (20) @(negedge clk);
    chk("no_write_after_rst", nwr - n0, 0);
    rd("post_rst_status", 2'd3, AI | 8'h02);
    rd("post_rst_cx", 2'd0, 8'd0);
    chk("final_queue", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
